// File: rtl/reduce_tree_acc.sv
// Pipelined FAN-ary reduction tree feeding a multi-beat accumulator with
// valid/ready flow control; emits a full sum or a rounded mean per group.
module reduce_tree_node #(
  parameter int W      = 16,
  parameter int FAN    = 4,
  parameter int SIGNED = 0,
  localparam int G     = $clog2(FAN)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [FAN-1:0][W-1:0] i_ops,
  output logic [W+G-1:0]        o_sum
);
  logic [W+G-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < FAN; i++)
      w_sum = w_sum + {{G{(SIGNED != 0) && i_ops[i][W-1]}}, i_ops[i]};
  end

  always_ff @(posedge clk)
    if (en) o_sum <= w_sum;
endmodule

module reduce_tree_acc #(
  parameter int IN_W   = 16,
  parameter int N_IN   = 64,
  parameter int FAN    = 4,
  parameter int SIGNED = 0,
  localparam int G     = $clog2(FAN),
  localparam int LVL   = $clog2(N_IN) / G,
  localparam int S     = LVL * G,
  localparam int SUM_W = IN_W + S,
  localparam int ACC_W = SUM_W + 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0][IN_W-1:0]  in_data,
  input  logic [7:0]                 acc_len,
  input  logic                       mode_avg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic [7:0]                 out_last_cnt
);
  // Bit offset of level k inside the flat bus; level 0 holds the raw operands.
  function automatic int lvl_off(int k);
    int off = 0;
    int n   = N_IN;
    for (int j = 0; j < k; j++) begin
      off += n * (IN_W + j * G);
      n    = n / FAN;
    end
    return off;
  endfunction

  localparam int BUS_W = lvl_off(LVL + 1);

  logic [BUS_W-1:0] w_bus;
  logic             w_en;
  logic [LVL-1:0]   r_vld_pipe;
  logic [ACC_W-1:0] r_acc, r_out_data;
  logic [7:0]       r_cnt, r_len_q, r_out_cnt;
  logic             r_avg_q, r_out_valid;

  assign w_en     = !r_out_valid | out_ready;
  assign in_ready = w_en;
  assign w_bus[N_IN*IN_W-1:0] = in_data;

  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    localparam int W  = IN_W + (k - 1) * G;
    localparam int NN = N_IN / (FAN ** k);
    for (genvar n = 0; n < NN; n++) begin : g_node
      reduce_tree_node #(.W(W), .FAN(FAN), .SIGNED(SIGNED)) u_node (
        .clk   (clk),
        .en    (w_en),
        .i_ops (w_bus[lvl_off(k-1) + n*FAN*W +: FAN*W]),
        .o_sum (w_bus[lvl_off(k) + n*(W+G) +: W+G])
      );
    end
  end

  logic [SUM_W-1:0] w_top;
  logic [ACC_W-1:0] w_t, w_r, w_rnd, w_res;
  logic [7:0]       w_len;
  logic             w_avg, w_fin;

  assign w_top = w_bus[lvl_off(LVL) +: SUM_W];

  // Group parameters come from the inputs only when the first beat lands.
  always_comb begin
    w_t   = {{8{(SIGNED != 0) && w_top[SUM_W-1]}}, w_top};
    w_len = r_len_q;
    w_avg = r_avg_q;
    if (r_cnt == 8'd0) begin
      w_len = (acc_len == 8'd0) ? 8'd1 : acc_len;
      w_avg = mode_avg;
    end
    w_fin = ({1'b0, r_cnt} + 9'd1) >= {1'b0, w_len};
    w_r   = r_acc + w_t;
    w_rnd = w_r + (ACC_W'(1) << (S - 1));
    if (SIGNED != 0) w_res = $unsigned($signed(w_rnd) >>> S);
    else             w_res = w_rnd >> S;
    if (!w_avg) w_res = w_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_q     <= 8'd1;
      r_avg_q     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
    end else if (w_en) begin
      r_vld_pipe[0] <= in_valid;
      for (int i = 1; i < LVL; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      if (r_vld_pipe[LVL-1]) begin
        if (r_cnt == 8'd0) begin
          r_len_q <= w_len;
          r_avg_q <= w_avg;
        end
        if (w_fin) begin
          r_out_data  <= w_res;
          r_out_cnt   <= r_cnt + 8'd1;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc       <= w_r;
          r_cnt       <= r_cnt + 8'd1;
          r_out_valid <= 1'b0;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_last_cnt = r_out_cnt;
endmodule

// File: tb/tb_reduce_tree_acc.sv
// Directed bench for reduce_tree_acc: unsigned and signed instances share
// stimulus; table of single-group vectors plus stall, mid-group and reset cases.
module tb_reduce_tree_acc;
  localparam int LVL   = 3;
  localparam int ACC_W = 30;

  logic clk = 0, rst = 1, in_valid = 0, mode_avg = 0, out_ready = 1;
  logic [63:0][15:0] din;
  logic [7:0] acc_len = 8'd1;
  logic uo_ready, uo_valid, so_ready, so_valid;
  logic [ACC_W-1:0] uo_data, so_data;
  logic [7:0] uo_cnt, so_cnt;

  int total = 0, bad = 0, hs = 0, lat, nb;

  always #5 clk = ~clk;

  reduce_tree_acc #(.SIGNED(0)) u_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(uo_ready), .in_data(din),
    .acc_len(acc_len), .mode_avg(mode_avg), .out_valid(uo_valid), .out_ready(out_ready),
    .out_data(uo_data), .out_last_cnt(uo_cnt));

  reduce_tree_acc #(.SIGNED(1)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(so_ready), .in_data(din),
    .acc_len(acc_len), .mode_avg(mode_avg), .out_valid(so_valid), .out_ready(out_ready),
    .out_data(so_data), .out_last_cnt(so_cnt));

  always @(negedge clk) if (uo_valid && out_ready) hs++;

  typedef struct {
    int          kind;   // 0 = all lanes val, 1 = lane index ramp
    logic [15:0] val;
    logic [7:0]  len;
    logic        avg;
    logic [29:0] exp_u;
    logic [29:0] exp_s;
    logic [7:0]  exp_cnt;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic set_data(input int kind, input logic [15:0] v);
    for (int i = 0; i < 64; i++) din[i] = (kind == 1) ? 16'(i) : v;
  endtask

  task automatic send(input int n, input logic [15:0] v);
    for (int b = 0; b < n; b++) begin
      set_data(0, v); in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic wait_out(output int l);
    l = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (uo_valid) begin l = n; break; end
    end
  endtask

  initial begin
    tv[0] = '{0, 16'h0001, 8'd1, 1'b0, 30'd64,      30'd64,         8'd1};
    tv[1] = '{1, 16'h0000, 8'd1, 1'b1, 30'd32,      30'd32,         8'd1};
    tv[2] = '{1, 16'h0000, 8'd1, 1'b0, 30'd2016,    30'd2016,       8'd1};
    tv[3] = '{0, 16'hFFFF, 8'd1, 1'b1, 30'd65535,   30'h3FFFFFFF,   8'd1};
    tv[4] = '{0, 16'hFFFF, 8'd1, 1'b0, 30'd4194240, 30'h3FFFFFC0,   8'd1};
    tv[5] = '{0, 16'h0002, 8'd4, 1'b0, 30'd512,     30'd512,        8'd4};
    tv[6] = '{0, 16'h0001, 8'd0, 1'b0, 30'd64,      30'd64,         8'd1};
    tv[7] = '{0, 16'h0003, 8'd2, 1'b1, 30'd6,       30'd6,          8'd2};
    tv[8] = '{0, 16'hFFFF, 8'd2, 1'b1, 30'd131070,  30'h3FFFFFFE,   8'd2};
    tv[9] = '{0, 16'h8000, 8'd1, 1'b0, 30'd2097152, 30'h3FE00000,   8'd1};
    set_data(0, 16'd0);

    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", {uo_valid, so_valid}, 2'b00);
    chk("rst_data", uo_data | so_data, 0);
    chk("rst_cnt", uo_cnt | so_cnt, 0);
    chk("rst_ready", {uo_ready, so_ready}, 2'b11);

    for (int v = 0; v < 10; v++) begin
      acc_len = tv[v].len; mode_avg = tv[v].avg; hs = 0;
      nb = (tv[v].len == 0) ? 1 : int'(tv[v].len);
      for (int b = 0; b < nb; b++) begin
        set_data(tv[v].kind, tv[v].val); in_valid = 1;
        @(posedge clk); #1;
      end
      in_valid = 0;
      wait_out(lat);
      chk($sformatf("v%0d_lat", v), lat, LVL);
      chk($sformatf("v%0d_udata", v), uo_data, tv[v].exp_u);
      chk($sformatf("v%0d_sdata", v), so_data, tv[v].exp_s);
      chk($sformatf("v%0d_cnt", v), uo_cnt, tv[v].exp_cnt);
      repeat (2) begin @(posedge clk); #1; end
      chk($sformatf("v%0d_nres", v), hs, 1);
    end

    // Group settings latched on first beat; bubbles inside a group are ignored.
    hs = 0; acc_len = 8'd4; mode_avg = 0;
    send(2, 16'd2);
    repeat (5) begin @(posedge clk); #1; end
    chk("mid_noout", uo_valid, 0);
    acc_len = 8'd1; mode_avg = 1;
    send(2, 16'd2);
    wait_out(lat);
    chk("mid_lat", lat, LVL);
    chk("mid_data", uo_data, 512);
    chk("mid_cnt", uo_cnt, 4);
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_nres", hs, 1);

    // Stream of 10 single-beat groups with a 5-cycle backpressure window.
    hs = 0; acc_len = 8'd1; mode_avg = 0;
    fork
      begin : prod
        int g, tries;
        logic r;
        g = 0; tries = 0;
        while (g < 10 && tries < 400) begin
          set_data(0, 16'(g + 1)); in_valid = 1;
          @(negedge clk); r = uo_ready;
          @(posedge clk); #1; tries++;
          if (r) g++;
        end
        in_valid = 0;
        chk("prod_sent", g, 10);
      end
      begin : cons
        int nrecv, stall_left, c;
        bit stalled, hold;
        logic [ACC_W-1:0] held;
        nrecv = 0; stall_left = 0; stalled = 0; hold = 0; held = '0;
        for (c = 0; c < 300 && nrecv < 10; c++) begin
          @(posedge clk); #1;
          if (!stalled && nrecv == 3 && uo_valid) begin
            out_ready = 0; stall_left = 5; stalled = 1;
          end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) out_ready = 1;
          end
          @(negedge clk);
          if (uo_valid && !out_ready) begin
            chk("stall_ready", uo_ready, 0);
            if (hold) chk("stall_data", uo_data, held);
            held = uo_data; hold = 1;
          end else if (uo_valid) begin
            chk($sformatf("stream_r%0d", nrecv), uo_data, 64 * (nrecv + 1));
            nrecv++; hold = 0;
          end
        end
        out_ready = 1;
        chk("stream_stalled", stalled, 1);
        chk("stream_nrecv", nrecv, 10);
      end
    join
    repeat (6) begin @(posedge clk); #1; end
    chk("stream_hs", hs, 10);

    // Reset mid-group drops the partial sum.
    acc_len = 8'd4; mode_avg = 0;
    send(2, 16'd1);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1; @(posedge clk); #1; rst = 0;
    chk("mrst_valid", uo_valid, 0);
    chk("mrst_data", uo_data, 0);
    chk("mrst_cnt", uo_cnt, 0);
    chk("mrst_ready", uo_ready, 1);
    hs = 0;
    send(4, 16'd1);
    wait_out(lat);
    chk("mrst_lat", lat, LVL);
    chk("mrst_sum", uo_data, 256);
    chk("mrst_cnt4", uo_cnt, 4);
    repeat (2) begin @(posedge clk); #1; end
    chk("mrst_nres", hs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reduce_tree_acc.md
# reduce_tree_acc

Parametrised, pipelined FAN-ary reduction tree with a valid/ready handshake and a multi-beat accumulator. Each accepted beat of N_IN operands is summed over LVL registered adder levels. The level sums are then accumulated over a run-time number of beats. The block emits one full-precision or rounded-mean result per group. It replaces the fixed 64-input, 4-ary, free-running tree in the SIMD MAC array reduction path.

## Interface
- IN_W, 16, operand width (2×MAC_BW)
- N_IN, 64, operands per beat; must be a power of FAN
- FAN, 4, adder fan-in per level; power of 2, ≥2
- SIGNED, 0, 1 = two's-complement operands with arithmetic shift; 0 = unsigned
- Derived, not overridable:
  - G = log2(FAN)
  - LVL = log_FAN(N_IN)
  - S = LVL·G
  - SUM_W = IN_W + S
  - ACC_W = SUM_W + 8
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_data  in  [N_IN-1:0][IN_W]  operands
- acc_len  in  8  beats per group; 0 is treated as 1
- mode_avg  in  1  1 = rounded mean over N_IN; 0 = full sum
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_data  out  ACC_W  group result
- out_last_cnt  out  8  number of beats accumulated into out_data

## Operation
- Level k (1..LVL) registers N_IN/FAN^k partial sums, each IN_W + k·G bits wide.
  - Each partial sum adds FAN consecutive lower-level values, with no truncation.
  - Operands and partial sums are zero-extended, or sign-extended when SIGNED=1.
- Every tree level carries a valid bit. Bubbles propagate as invalid and do not update the accumulator.
- Global stage enable: en = !out_valid | out_ready. All pipeline registers hold when en=0. in_ready = en.
- The accumulator stage has these registers:
  - acc (ACC_W), cnt (8)
  - len_q (8), avg_q (1)
  - out_data, out_valid
- Accumulator update, on en with a valid level-LVL sum T:
  - If cnt==0, first latch len_q ← max(acc_len,1) and avg_q ← mode_avg. acc_len and mode_avg changes mid-group are ignored.
  - Not final (cnt+1 < len_q): acc ← acc+T, cnt ← cnt+1, out_valid ← 0.
  - Final: R = acc+T; out_data ← avg_q ? (R + 2^(S-1)) >> S : R; out_last_cnt ← cnt+1; out_valid ← 1; acc ← 0; cnt ← 0.
  - The shift in the final step is arithmetic when SIGNED=1. The result is extended to ACC_W.
- On en with no valid T: out_valid ← 0 (the previous result was consumed); acc and cnt hold.
- Overflow: ACC_W covers 255 full-scale beats, so no wrap is possible within a group.

## Timing
- Reset: all valid bits, acc, cnt, out_valid, out_data and out_last_cnt are 0. len_q = 1, avg_q = 0. in_ready = 1 after reset.
- Reset mid-group discards partial accumulation and all in-flight beats. No result is emitted for that group.
- Latency, with no stall:
  - A beat accepted at edge e loads level 1 at e and level LVL at e+LVL-1.
  - The accumulator/output register is updated at e+LVL.
  - For a final beat, out_valid is high for the cycle after edge e+LVL (3 cycles with defaults).
- Throughput is one beat per cycle while out_ready=1 or out_valid=0.
- While out_valid=1 and out_ready=0:
  - out_data and out_last_cnt are stable.
  - in_ready=0 and no stage advances.
- Simultaneous events:
  - out_ready=1 with a new final beat at level LVL: the new result replaces the old one in the same cycle, and out_valid stays 1.
  - in_valid with in_ready=0: the beat is not taken, and the source must hold it.

## Test plan
- Defaults (LVL=3, S=6, ACC_W=30). All in_data=1, acc_len=1, mode_avg=0, one beat → out_valid 3 cycles after acceptance; out_data=64; out_last_cnt=1.
- in_data[i]=i, mode_avg=1 → out_data=(2016+32)>>6=32. All 0xFFFF with mode_avg=1 → 65535; with mode_avg=0 → 4194240.
- acc_len=4, four back-to-back beats of all 2 → exactly one out_valid, carrying out_data=512 and out_last_cnt=4.
  - Change acc_len to 1 after beat 2 → no effect on the current group.
- Stream of 10 groups (acc_len=1) with out_ready low for 5 cycles at group 3:
  - in_ready falls while out_valid=1; out_data is stable.
  - All 10 results are delivered in order, with none lost or duplicated.
- SIGNED=1, all in_data=0xFFFF:
  - mode_avg=0 → out_data=0x3FFFFFC0 (−64).
  - mode_avg=1 → 0x3FFFFFFF (−1).
- acc_len=4, rst pulsed for 1 cycle after 2 beats:
  - Outputs are 0 on the next cycle.
  - A new 4-beat group of all 1 yields 256, not 384.
